// File: rtl/clock_input_conditioner.sv
// clock_input_conditioner
// Front end for the digital clock/alarm core. Synchronizes and debounces the
// raw push-buttons and alarm switch, generates the 1-per-second Pulse tick,
// and turns the three advance buttons into single-cycle strobes.
// Optional feature macro: CLOCK_INPUT_AUTOREPEAT_EN. When defined, a held
// advance button auto-repeats (IDLE/HOLD/REPEAT FSM). When undefined, each
// press gives exactly one strobe and REPEAT_DELAY/REPEAT_PERIOD are unused.
module clock_input_conditioner #(
  parameter int TICKS_PER_SEC  = 50_000_000,
  parameter int DEBOUNCE_TICKS = 500_000,
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_PERIOD  = 10_000_000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic BtnTimeset,
  input  logic BtnAlarmset,
  input  logic BtnMin,
  input  logic BtnHrs,
  input  logic BtnDay,
  input  logic SwAlarmon,
  output logic Pulse,
  output logic Timeset,
  output logic Alarmset,
  output logic Alarmon,
  output logic Minadv,
  output logic Hrsadv,
  output logic Dayadv
);

  // Bit positions of the six raw inputs inside the packed input vectors.
  localparam int IDX_TIMESET  = 0;
  localparam int IDX_ALARMSET = 1;
  localparam int IDX_MIN      = 2;
  localparam int IDX_DAY      = 4;
  localparam int IDX_ALARMON  = 5;
  localparam int NUM_IN       = 6;

  // Prescaler counts 0..TICKS_PER_SEC-1; debounce counter never stores more
  // than DEBOUNCE_TICKS-1 but is sized for the threshold itself.
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

  // Reject parameter values that cannot produce a working front end.
  if (TICKS_PER_SEC < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 0 || REPEAT_PERIOD < 0)
  begin : g_bad_params
    $error("clock_input_conditioner: illegal parameter value");
  end

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] sync_meta;
  logic [NUM_IN-1:0] sync_q;
  logic [NUM_IN-1:0] deb;

  assign raw = {SwAlarmon, BtnDay, BtnHrs, BtnMin, BtnAlarmset, BtnTimeset};

  // Two-flop synchronizer bringing every raw input into the Clk domain.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge; blocking = here would collapse the two stages.
    if (!Reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          level;

    // Debounce: level flips only after DEBOUNCE_TICKS consecutive disagreeing cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_q[i] == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_TICKS - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end

    assign deb[i] = level;
  end

  assign Timeset  = deb[IDX_TIMESET];
  assign Alarmset = deb[IDX_ALARMSET];
  assign Alarmon  = deb[IDX_ALARMON];

  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_next;

  // Prescaler next value: wrap to 0 after TICKS_PER_SEC-1.
  always_comb begin
    pre_next = (pre_cnt == PW'(TICKS_PER_SEC - 1)) ? '0 : pre_cnt + PW'(1);
  end

  // Prescaler register; Pulse is high in the cycle the counter holds TICKS_PER_SEC-1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_cnt <= '0;
      Pulse   <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      Pulse   <= (pre_next == PW'(TICKS_PER_SEC - 1));
    end
  end

  logic [2:0] adv_level;
  logic [2:0] adv_strobe;

  assign adv_level = deb[IDX_DAY:IDX_MIN];

`ifdef CLOCK_INPUT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } adv_state_t;

  for (genvar j = 0; j < 3; j++) begin : g_adv
    adv_state_t    state;
    adv_state_t    state_next;
    logic [RW-1:0] cnt;
    logic [RW-1:0] cnt_next;
    logic          strobe;
    logic          strobe_next;

    // Advance FSM next state: release wins over a coincident counter expiry.
    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_next  = state;
      cnt_next    = cnt;
      strobe_next = 1'b0;
      case (state)
        IDLE: begin
          if (adv_level[j]) begin
            state_next  = HOLD;
            cnt_next    = RW'(REPEAT_DELAY);
            strobe_next = 1'b1;
          end
        end
        HOLD, REPEAT: begin
          if (!adv_level[j]) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt <= RW'(1)) begin
            state_next  = REPEAT;
            cnt_next    = RW'(REPEAT_PERIOD);
            strobe_next = 1'b1;
          end else begin
            cnt_next = cnt - RW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // Advance FSM state, counter and registered strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state  <= IDLE;
        cnt    <= '0;
        strobe <= 1'b0;
      end else begin
        state  <= state_next;
        cnt    <= cnt_next;
        strobe <= strobe_next;
      end
    end

    assign adv_strobe[j] = strobe;
  end
`else
  for (genvar j = 0; j < 3; j++) begin : g_adv
    logic level_q;
    logic strobe;

    // One registered strobe per debounced rising edge; holding gives nothing more.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        level_q <= 1'b0;
        strobe  <= 1'b0;
      end else begin
        level_q <= adv_level[j];
        strobe  <= adv_level[j] & ~level_q;
      end
    end

    assign adv_strobe[j] = strobe;
  end
`endif

  assign Minadv = adv_strobe[0];
  assign Hrsadv = adv_strobe[1];
  assign Dayadv = adv_strobe[2];

endmodule

// File: doc/clock_input_conditioner.md
# clock_input_conditioner

- Front-end stage for the lab 2 digital clock/alarm top level.
- Runs on the fast board clock and turns the raw, asynchronous, bouncing push-buttons and switch into the clean signals the clock core consumes:
  - debounced `Timeset`, `Alarmset` and `Alarmon` levels;
  - single-cycle `Minadv`, `Hrsadv` and `Dayadv` strobes, with hold-to-repeat;
  - the 1-per-second `Pulse` tick.
- Its outputs connect directly to the identically named inputs of the clock core.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 50_000_000: `Clk` cycles per `Pulse` period. Must be ≥ 2.
- `DEBOUNCE_TICKS`, default 500_000: consecutive stable cycles required before a debounced level changes. Must be ≥ 1.
- `REPEAT_DELAY`, default 25_000_000: cycles an advance button is held before auto-repeat begins.
- `REPEAT_PERIOD`, default 10_000_000: cycles between auto-repeat strobes.

Ports:
- `Clk` in 1: the single clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `BtnTimeset`, `BtnAlarmset`, `BtnMin`, `BtnHrs`, `BtnDay`, `SwAlarmon` in 1 each: raw asynchronous inputs, active-high.
- `Pulse` out 1: one-cycle strobe every `TICKS_PER_SEC` cycles.
- `Timeset`, `Alarmset`, `Alarmon` out 1 each: debounced levels.
- `Minadv`, `Hrsadv`, `Dayadv` out 1 each: one-cycle advance strobes.

## Operation

- **Synchronizer:** each raw input passes through a 2-flop synchronizer.
- **Debounce, per input:**
  - The counter increments each cycle the synchronized value differs from the debounced level.
  - The counter clears whenever the two agree.
  - When the counter reaches `DEBOUNCE_TICKS`, the debounced level flips and the counter clears.
- **Level outputs:** `Timeset`, `Alarmset` and `Alarmon` are the debounced levels, driven straight from their registers.
- **Prescaler:**
  - Counter counts 0..`TICKS_PER_SEC`-1 and wraps to 0.
  - `Pulse` is registered; it is high for exactly the one cycle in which the counter equals `TICKS_PER_SEC`-1.
- **Advance FSM:** one independent FSM per advance button, with states IDLE, HOLD and REPEAT.
  - IDLE→HOLD on a debounced rising edge: emit a strobe and load the delay counter with `REPEAT_DELAY`.
  - HOLD: decrement the counter. At 0, emit a strobe, go to REPEAT and load `REPEAT_PERIOD`.
  - REPEAT: decrement the counter. At 0, emit a strobe and reload `REPEAT_PERIOD`.
  - From any state, debounced level low → IDLE, with no strobe in that cycle. Release takes priority over a coincident counter expiry.
- **Strobe outputs:** all strobes are registered and last exactly 1 cycle.
- **Independence:** simultaneous presses on different buttons give independent strobes, which may coincide. A strobe coinciding with `Pulse` is passed unchanged; arbitration belongs to the clock core.
- **Widths:** each counter is `$clog2` of its maximum value plus one. No counter may overflow or wrap except the prescaler.

## Timing

- **Reset values:** while `Reset_n`=0, every output is 0. All synchronizer and debounce registers are 0, all counters are 0 and all FSMs are IDLE. The reset takes effect immediately (asynchronous).
- **Reset mid-operation:** everything clears, with no residual strobe. A button still held at reset release is debounced afresh and yields a new first strobe.
- **Latency, raw input stable before edge 0:**
  - Synchronizer output updates at edge 1.
  - Debounced level flips at edge 1+`DEBOUNCE_TICKS`.
  - First advance strobe is high after edge 2+`DEBOUNCE_TICKS`.
- **Release latency:** the same, so strobes already scheduled up to edge 1+`DEBOUNCE_TICKS` after release still occur.
- **First `Pulse`:** high in cycle `TICKS_PER_SEC` after reset release (counter equals `TICKS_PER_SEC`-1); then every `TICKS_PER_SEC` cycles.
- **Bounce rejection:** a pulse or glitch shorter than `DEBOUNCE_TICKS` synchronized cycles never changes a debounced level.

## Configuration

- Macro: `CLOCK_INPUT_AUTOREPEAT_EN`.
- **Defined:** the full IDLE/HOLD/REPEAT behaviour above.
- **Undefined:** the HOLD and REPEAT states and their counters are not built. Each debounced rising edge gives exactly one strobe, and holding the button gives nothing further. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan

All scenarios use `TICKS_PER_SEC`=10, `DEBOUNCE_TICKS`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5. Edge numbers are relative to the stimulus.

- **Idle run:** reset released, no buttons for 35 cycles → `Pulse` high in cycles 10, 20 and 30 only; every other output 0.
- **Bounce rejection:** `BtnMin` toggles every 2 cycles for 20 cycles, then held at 0 → `Minadv` never asserts and the debounced level stays 0.
- **Short press:** `BtnMin` high for cycles 0..4, then low → exactly one `Minadv`, high after edge 6.
- **Hold with repeat:** `BtnHrs` held high for cycles 0..49, with `CLOCK_INPUT_AUTOREPEAT_EN` defined → `Hrsadv` after edges 6, 26, 31, 36, 41, 46 and 51, and none afterwards.
  - Same stimulus with the macro undefined → only the strobe after edge 6.
- **Reset mid-hold:** `BtnDay` held; `Reset_n` pulled low during HOLD and released at edge R → all outputs 0 at once; one `Dayadv` after edge R+6, then repeats resume from HOLD timing.
- **Level input:** `BtnTimeset` high for cycles 0..9 → `Timeset` high from edge 5 until edge 15, then 0.
